// File: rtl/xbar_slave_arbiter.sv
// Per-slave round-robin arbiter for the cross-bar: one master owns the slave port
// for a whole transaction (ack for writes, ack then resp for reads).
module xbar_slave_arbiter #(
    parameter int NMASTERS = 2,
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter bit SLAVE_ID = 1'b0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [NMASTERS-1:0]          m_req,
    input  logic [NMASTERS-1:0]          m_cmd,
    input  logic [NMASTERS*AWIDTH-1:0]   m_addr,
    input  logic [NMASTERS*DWIDTH-1:0]   m_wdata,
    output logic [NMASTERS-1:0]          m_ack,
    output logic [NMASTERS-1:0]          m_resp,
    output logic [NMASTERS*DWIDTH-1:0]   m_rdata,
    output logic                         s_req,
    output logic                         s_cmd,
    output logic [AWIDTH-1:0]            s_addr,
    output logic [DWIDTH-1:0]            s_wdata,
    input  logic                         s_ack,
    input  logic                         s_resp,
    input  logic [DWIDTH-1:0]            s_rdata,
    output logic [NMASTERS-1:0]          grant
);

    localparam int PW = $clog2(NMASTERS);

    typedef enum logic [1:0] {ARB, BUSY, WAIT_RESP, RELEASE} state_t;

    state_t              state, state_next;
    logic [NMASTERS-1:0] grant_next;
    logic [PW-1:0]       ptr, ptr_next;
    logic [PW-1:0]       owner, owner_next;
    logic [NMASTERS-1:0] eligible;
    logic                found;
    logic [PW-1:0]       winner;
    logic [PW-1:0]       cand;
    logic                granted;
    logic                cur_req;
    logic                cur_cmd;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NMASTERS) s = s - NMASTERS;
        return PW'(s);
    endfunction

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NMASTERS; i++)
            eligible[i] = m_req[i] && (m_addr[i*AWIDTH + AWIDTH - 1] == SLAVE_ID);
    end

    // Round-robin search starting at ptr; the first eligible master wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NMASTERS; k++) begin
            cand = wrap_add(ptr, k);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign granted = |grant;
    assign cur_req = granted & m_req[owner];
    assign cur_cmd = granted & m_cmd[owner];

    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        owner_next = owner;
        case (state)
            ARB: begin
                if (found) begin
                    grant_next = NMASTERS'(1) << winner;
                    owner_next = winner;
                    ptr_next   = wrap_add(winner, 1);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!cur_req) begin
                    grant_next = '0;
                    state_next = ARB;
                end else if (s_ack) begin
                    if (cur_cmd || s_resp) state_next = RELEASE;
                    else                   state_next = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (s_resp) state_next = RELEASE;
            end
            RELEASE: begin
                if (!cur_req) begin
                    grant_next = '0;
                    state_next = ARB;
                end
            end
            default: begin
                grant_next = '0;
                state_next = ARB;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= ARB;
            grant <= '0;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            ptr   <= ptr_next;
            owner <= owner_next;
        end
    end

    // Forward path comes from the registered owner; return path is gated by grant and state.
    always_comb begin
        s_req   = (state == BUSY) && cur_req;
        s_cmd   = cur_cmd;
        s_addr  = granted ? m_addr[int'(owner)*AWIDTH +: AWIDTH] : '0;
        s_wdata = granted ? m_wdata[int'(owner)*DWIDTH +: DWIDTH] : '0;
        m_ack   = '0;
        m_resp  = '0;
        m_rdata = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            m_ack[i]  = s_ack & grant[i] & (state == BUSY);
            m_resp[i] = s_resp & grant[i] & ((state == BUSY) || (state == WAIT_RESP));
            m_rdata[i*DWIDTH +: DWIDTH] = grant[i] ? s_rdata : '0;
        end
    end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Directed bench for xbar_slave_arbiter with two masters and SLAVE_ID=1.
module tb_xbar_slave_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [1:0]  m_req;
    logic [1:0]  m_cmd;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_ack;
    logic [1:0]  m_resp;
    logic [63:0] m_rdata;
    logic        s_req;
    logic        s_cmd;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_ack;
    logic        s_resp;
    logic [31:0] s_rdata;
    logic [1:0]  grant;

    int vectors = 0;
    int miscompares = 0;

    xbar_slave_arbiter #(.NMASTERS(2), .AWIDTH(32), .DWIDTH(32), .SLAVE_ID(1'b1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
        .grant(grant)
    );

    always #5 aclk = ~aclk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] cmd,
                                 input logic ack, input logic resp);
        m_req  = req;
        m_cmd  = cmd;
        s_ack  = ack;
        s_resp = resp;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        s_rdata = '0;
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_grant", 64'(grant), 64'h0);
        checkOutput("reset_sreq", 64'(s_req), 64'h0);
        checkOutput("reset_saddr", 64'(s_addr), 64'h0);
        aresetn = 1'b1;

        // Single write from master0
        m_addr  = {32'h0000_0000, 32'h8000_0000};
        m_wdata = {32'h0000_0000, 32'hA5A5_A5A5};
        applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
        checkOutput("wr_pre_grant", 64'(grant), 64'h0);
        checkOutput("wr_pre_sreq", 64'(s_req), 64'h0);
        tick();
        checkOutput("wr_grant", 64'(grant), 64'h1);
        checkOutput("wr_sreq", 64'(s_req), 64'h1);
        checkOutput("wr_wdata", 64'(s_wdata), 64'hA5A5_A5A5);
        checkOutput("wr_scmd", 64'(s_cmd), 64'h1);
        applyStimulus(2'b01, 2'b01, 1'b1, 1'b0);
        checkOutput("wr_mack", 64'(m_ack), 64'h1);
        tick();
        applyStimulus(2'b00, 2'b01, 1'b0, 1'b0);
        checkOutput("wr_release_sreq", 64'(s_req), 64'h0);
        checkOutput("wr_release_grant", 64'(grant), 64'h1);
        tick();
        checkOutput("wr_idle_grant", 64'(grant), 64'h0);

        // Read from master1 with response three cycles after ack
        m_addr = {32'h8000_0010, 32'h0000_0000};
        applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
        tick();
        checkOutput("rd_grant", 64'(grant), 64'h2);
        checkOutput("rd_sreq", 64'(s_req), 64'h1);
        checkOutput("rd_saddr", 64'(s_addr), 64'h8000_0010);
        checkOutput("rd_scmd", 64'(s_cmd), 64'h0);
        applyStimulus(2'b10, 2'b00, 1'b1, 1'b0);
        checkOutput("rd_mack", 64'(m_ack), 64'h2);
        checkOutput("rd_mresp_early", 64'(m_resp), 64'h0);
        tick();
        applyStimulus(2'b10, 2'b00, 1'b0, 1'b0);
        checkOutput("rd_wait_sreq", 64'(s_req), 64'h0);
        checkOutput("rd_wait_grant", 64'(grant), 64'h2);
        tick();
        checkOutput("rd_wait_grant2", 64'(grant), 64'h2);
        tick();
        s_rdata = 32'h1234_5678;
        applyStimulus(2'b10, 2'b00, 1'b0, 1'b1);
        checkOutput("rd_mresp", 64'(m_resp), 64'h2);
        checkOutput("rd_mrdata", m_rdata, {32'h1234_5678, 32'h0000_0000});
        checkOutput("rd_resp_grant", 64'(grant), 64'h2);
        tick();
        s_rdata = '0;
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        tick();
        checkOutput("rd_idle_grant", 64'(grant), 64'h0);

        // Fairness from reset: both masters keep re-requesting writes
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        m_addr  = {32'h8000_0004, 32'h8000_0008};
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b0);
        tick();
        for (int t = 0; t < 6; t++) begin
            checkOutput($sformatf("fair_grant_%0d", t), 64'(grant),
                        (t % 2 == 0) ? 64'h1 : 64'h2);
            applyStimulus(2'b11, 2'b11, 1'b1, 1'b0);
            tick();
            applyStimulus((t % 2 == 0) ? 2'b10 : 2'b01, 2'b11, 1'b0, 1'b0);
            checkOutput($sformatf("fair_gap1_sreq_%0d", t), 64'(s_req), 64'h0);
            tick();
            applyStimulus(2'b11, 2'b11, 1'b0, 1'b0);
            checkOutput($sformatf("fair_gap2_grant_%0d", t), 64'(grant), 64'h0);
            tick();
        end
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        tick();

        // Address filter: MSB does not select this slave
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        m_addr  = {32'h0000_0000, 32'h7FFF_FFFF};
        applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
        for (int t = 0; t < 5; t++) begin
            tick();
            checkOutput($sformatf("filter_grant_%0d", t), 64'(grant), 64'h0);
            checkOutput($sformatf("filter_sreq_%0d", t), 64'(s_req), 64'h0);
        end

        // Abort before ack, late ack dropped, pointer moved to master1
        m_addr = {32'h8000_0000, 32'h8000_0000};
        applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
        tick();
        checkOutput("abort_grant", 64'(grant), 64'h1);
        applyStimulus(2'b00, 2'b01, 1'b0, 1'b0);
        checkOutput("abort_sreq", 64'(s_req), 64'h0);
        tick();
        checkOutput("abort_idle_grant", 64'(grant), 64'h0);
        applyStimulus(2'b00, 2'b01, 1'b1, 1'b0);
        checkOutput("abort_late_ack", 64'(m_ack), 64'h0);
        applyStimulus(2'b11, 2'b11, 1'b0, 1'b0);
        tick();
        checkOutput("abort_ptr_grant", 64'(grant), 64'h2);
        applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
        tick();

        // Reset while waiting for a read response
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
        tick();
        applyStimulus(2'b01, 2'b00, 1'b1, 1'b0);
        tick();
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
        checkOutput("rst_wait_grant", 64'(grant), 64'h1);
        aresetn = 1'b0;
        tick();
        applyStimulus(2'b01, 2'b00, 1'b0, 1'b1);
        checkOutput("rst_grant", 64'(grant), 64'h0);
        checkOutput("rst_sreq", 64'(s_req), 64'h0);
        checkOutput("rst_mresp", 64'(m_resp), 64'h0);
        aresetn = 1'b1;
        applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
        tick();
        checkOutput("rst_first_winner", 64'(grant), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xbar_slave_arbiter.md
# xbar_slave_arbiter

Per-slave arbiter for the cross-bar: shares one slave port between NMASTERS master ports using round-robin priority. It sits between the masters' request/command buses and one slave's read/write handshake port, one instance per slave. Each instance accepts only requests whose address MSB selects its slave (SLAVE_ID). It holds a grant for a whole transaction: through ack for writes, and through ack then resp for reads.

## Interface
Reset is aresetn, synchronous, active-low; clock is aclk.

**Parameters**
- NMASTERS, 2: number of master ports; must be ≥2.
- AWIDTH, 32: address width.
- DWIDTH, 32: data width.
- SLAVE_ID, 0: value of addr[AWIDTH-1] that selects this slave.

**Ports**
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- m_req  in  NMASTERS  per-master request
- m_cmd  in  NMASTERS  per-master command: 1=write, 0=read
- m_addr  in  NMASTERS×AWIDTH  per-master address (packed, master i at [i*AWIDTH +: AWIDTH])
- m_wdata  in  NMASTERS×DWIDTH  per-master write data
- m_ack  out  NMASTERS  per-master ack
- m_resp  out  NMASTERS  per-master read-response valid
- m_rdata  out  NMASTERS×DWIDTH  per-master read data
- s_req  out  1  request to slave
- s_cmd  out  1  forwarded command
- s_addr  out  AWIDTH  forwarded address
- s_wdata  out  DWIDTH  forwarded write data
- s_ack  in  1  slave ack
- s_resp  in  1  slave read response valid
- s_rdata  in  DWIDTH  slave read data
- grant  out  NMASTERS  one-hot current owner; all-zero when idle

## Operation
- Master i is eligible when m_req[i]=1 and m_addr[i][AWIDTH-1]=SLAVE_ID.
- Round-robin pointer `ptr`, range 0..NMASTERS-1, reset value 0.
  - Search order: ptr, ptr+1, … modulo NMASTERS; the first eligible master wins.
  - On a grant to master g: ptr <= (g+1) mod NMASTERS.
- **ARB** (reset state): grant=0. If any master is eligible, register grant=onehot(g) and go to BUSY.
- **BUSY**: s_req = m_req[g].
  - m_req[g]=0 (abort): go to ARB.
  - s_ack=1 and m_cmd[g]=1 (write): go to RELEASE.
  - s_ack=1, m_cmd[g]=0 (read), s_resp=0: go to WAIT_RESP.
  - s_ack=1 and s_resp=1 in the same cycle (read): go to RELEASE.
- **WAIT_RESP**: s_req=0. On s_resp=1, go to RELEASE. No timeout; the arbiter waits indefinitely.
- **RELEASE**: s_req=0. When m_req[g]=0, go to ARB, with grant cleared on that transition. This check is evaluated in the same cycle RELEASE is entered.
- Forwarding (combinational from the registered grant):
  - s_cmd, s_addr, s_wdata = fields of master g; all zeros when grant=0.
- Return routing (combinational, gated by the registered grant):
  - m_ack[i] = s_ack & grant[i] & (state==BUSY).
  - m_resp[i] = s_resp & grant[i] & (state==BUSY or WAIT_RESP).
  - m_rdata[i] = grant[i] ? s_rdata : 0.
- A master never receives ack or resp while it is not granted. Slave pulses arriving in ARB or RELEASE are dropped.
- Reset, including mid-transaction: state=ARB, grant=0, ptr=0, s_req=0. All m_ack, m_resp and m_rdata are 0; s_cmd, s_addr and s_wdata are 0.

## Timing
- Arbitration latency: eligible m_req seen at edge N gives grant and s_req=1 from cycle N+1.
- Ack and resp pass through to the master with zero added latency.
- Back-to-back throughput, another master already waiting:
  - Write completing in BUSY at edge N: RELEASE at N+1.
  - If the master has already dropped req, ARB at N+2 and the new grant at N+3.
  - Minimum gap between s_req pulses is 2 idle cycles.
- Simultaneous eligible requests resolve by ptr only; m_cmd has no effect on priority.
- ptr updates only when a grant is made. An abort still advances ptr.

## Test plan
- Single write: master0 req, cmd=1, addr MSB=SLAVE_ID, wdata=0xA5A5A5A5. Required response:
  - s_req=1 one cycle later, with s_wdata=0xA5A5A5A5.
  - s_ack pulse → m_ack[0]=1 in the same cycle; m_ack[1]=0.
- Read with a delayed response: master1 read at addr 0x80000010 (SLAVE_ID=1); slave acks, then asserts s_resp 3 cycles later with rdata=0x12345678. Required response:
  - m_ack[1], then m_resp[1]=1 with m_rdata[1]=0x12345678.
  - grant stays 2'b10 throughout.
- Fairness: both masters hold eligible requests continuously for 6 transactions from reset. Required response: grants alternate 0,1,0,1,0,1.
- Address filter: master0 requests with addr MSB≠SLAVE_ID. Required response: grant stays 0 and s_req stays 0 indefinitely.
- Abort: master0 drops req in BUSY before s_ack. Required response:
  - Return to ARB the next cycle, then ptr=1.
  - A late s_ack produces no m_ack.
- Mid-read reset: aresetn=0 while in WAIT_RESP. Required response:
  - Next cycle grant=0, s_req=0, all m_resp=0.
  - After release, master0 wins first.
